// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame size, command bytes and frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_e;

  localparam int FRAME_BITS = 10;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  // Wire order after the start bit: data LSB first, odd parity, stop.
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// CPU-side request/status bundle of the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       wr;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output wr, din, input busy, done, err);
  modport slave  (input wr, din, output busy, done, err);
endinterface

// File: rtl/ps2_clk_filter.sv
// PS/2 pin synchronizer with ps2c falling-edge strobe.
// Define PS2_TX_FILTER_EN to require FILTER_LEN stable cycles before a ps2c level is accepted.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2c_s,
  output logic ps2d_s,
  output logic fall
);

  if (FILTER_LEN < 1) begin : g_len_chk
    $error("FILTER_LEN must be at least 1");
  end

  logic [1:0] c_sync_q;
  logic [1:0] d_sync_q;
  logic       c_prev_q;
  logic       c_lvl;

  // Idle bus is high, so reset the sync chain high to avoid a false fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      c_prev_q <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c};
      d_sync_q <= {d_sync_q[0], ps2d};
      c_prev_q <= c_lvl;
    end
  end

`ifdef PS2_TX_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;

  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (c_sync_q[1] != lvl_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) lvl_d = c_sync_q[1];
      else                              cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      lvl_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign c_lvl = lvl_q;
`else
  assign c_lvl = c_sync_q[1];
`endif

  assign ps2c_s = c_lvl;
  assign ps2d_s = d_sync_q[1];
  assign fall   = c_prev_q & ~c_lvl;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked-out frame, ack check.
// Optional ps2c glitch filter enabled by defining PS2_TX_FILTER_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ps2c,
  input  logic           ps2d,
  output logic           ps2c_oe,
  output logic           ps2d_oe,
  ps2_host_tx_if.slave   bus
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(FRAME_BITS);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [IW-1:0]         inh_q, inh_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  ps2d_oe_q, ps2d_oe_d;
  logic                  done_c, err_c;
  logic                  ps2c_s, ps2d_s, fall;
  logic                  to_run;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk    (clk),
    .rst    (rst),
    .ps2c   (ps2c),
    .ps2d   (ps2d),
    .ps2c_s (ps2c_s),
    .ps2d_s (ps2d_s),
    .fall   (fall)
  );

  assign to_run = (state_q inside {SHIFT, ACK, WAIT_IDLE});

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    inh_d     = inh_q;
    to_d      = to_q;
    ps2d_oe_d = ps2d_oe_q;
    done_c    = 1'b0;
    err_c     = 1'b0;

    if (to_run && to_q != TW'(TIMEOUT_CYCLES)) to_d = to_q + 1'b1;

    unique case (state_q)
      IDLE: if (bus.wr) begin
        frame_d = ps2_frame(bus.din);
        bit_d   = '0;
        inh_d   = '0;
        to_d    = '0;
        state_d = INHIBIT;
      end
      INHIBIT: begin
        if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
          ps2d_oe_d = 1'b1;
          state_d   = RTS;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      RTS: begin
        to_d    = '0;
        state_d = SHIFT;
      end
      // The device samples data on its rising edge, so each fall drives the next bit.
      SHIFT: if (fall) begin
        ps2d_oe_d = ~frame_q[bit_q];
        if (bit_q == BW'(FRAME_BITS - 1)) state_d = ACK;
        else                              bit_d   = bit_q + 1'b1;
      end
      ACK: if (fall) begin
        if (ps2d_s) begin
          err_c   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (ps2c_s && ps2d_s) begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (to_run && to_q == TW'(TIMEOUT_CYCLES)) begin
      ps2d_oe_d = 1'b0;
      done_c    = 1'b0;
      err_c     = 1'b1;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      inh_q     <= '0;
      to_q      <= '0;
      ps2d_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      inh_q     <= inh_d;
      to_q      <= to_d;
      ps2d_oe_q <= ps2d_oe_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  assign ps2c_oe  = (state_q inside {INHIBIT, RTS});
  assign ps2d_oe  = ps2d_oe_q;
  assign bus.busy = (state_q != IDLE);
  // A reset cycle abandons the transaction silently.
  assign bus.done = done_c & ~rst;
  assign bus.err  = err_c & ~rst;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 50;
  localparam int TMO  = 3000;
  localparam int FLT  = 8;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_c = 1'b1;
  logic dev_d = 1'b1;
  logic ps2c_oe, ps2d_oe;
  logic ps2c_pin, ps2d_pin;

  assign ps2c_pin = dev_c & ~ps2c_oe;
  assign ps2d_pin = dev_d & ~ps2d_oe;

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2c    (ps2c_pin),
    .ps2d    (ps2d_pin),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;
  logic prev_pulse = 1'b0;
  logic post_busy = 1'b1;

  always @(posedge clk) begin
    #2;
    if (bus.done) done_cnt++;
    if (bus.err) err_cnt++;
    if (bus.done && bus.err) both_cnt++;
    if (prev_pulse) post_busy = bus.busy;
    prev_pulse = bus.done | bus.err;
  end

  task automatic clear_counts();
    done_cnt  = 0;
    err_cnt   = 0;
    post_busy = 1'b1;
  endtask

  task automatic start_tx(input logic [7:0] b, output int oe_cyc, output int d_cyc,
                          output logic n1_ok, output logic busy_all);
    bus.wr  = 1'b1;
    bus.din = b;
    @(negedge clk);
    bus.wr   = 1'b0;
    n1_ok    = bus.busy & ps2c_oe;
    oe_cyc   = 0;
    d_cyc    = 0;
    busy_all = 1'b1;
    while (ps2c_oe && oe_cyc < INH + 100) begin
      oe_cyc++;
      if (ps2d_oe) d_cyc++;
      if (!bus.busy) busy_all = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic device_frame(input logic ack, input logic glitch, output logic [9:0] cap);
    for (int k = 0; k < 10; k++) begin
      if (glitch) begin
        repeat (12) @(negedge clk);
        dev_c = 1'b0;
        repeat (3) @(negedge clk);
        dev_c = 1'b1;
        repeat (HALF - 15) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_c = 1'b0;
      repeat (HALF) @(negedge clk);
      cap[k] = ps2d_pin;
      dev_c  = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    dev_d = ack;
    dev_c = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_c = 1'b1;
    repeat (4) @(negedge clk);
    dev_d = 1'b1;
  endtask

  task automatic wait_end(output logic hung);
    int n = 0;
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    hung = bus.busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    n_cmp++; if (ps2c_oe !== 1'b0) begin n_bad++; $display("FAIL rst_ps2c_oe got=%b want=0", ps2c_oe); end
    n_cmp++; if (ps2d_oe !== 1'b0) begin n_bad++; $display("FAIL rst_ps2d_oe got=%b want=0", ps2d_oe); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b want=0", bus.err); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL post_rst_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_send_ed();
    int oe_cyc, d_cyc; logic n1_ok, busy_all, hung; logic [9:0] cap;
    clear_counts();
    start_tx(PS2_CMD_SET_LED, oe_cyc, d_cyc, n1_ok, busy_all);
    n_cmp++; if (n1_ok !== 1'b1) begin n_bad++; $display("FAIL ed_busy_oe_n1 got=%b want=1", n1_ok); end
    n_cmp++; if (oe_cyc != INH + 1) begin n_bad++; $display("FAIL ed_ps2c_oe_cycles got=%0d want=%0d", oe_cyc, INH + 1); end
    n_cmp++; if (d_cyc != 1) begin n_bad++; $display("FAIL ed_rts_cycles got=%0d want=1", d_cyc); end
    n_cmp++; if (ps2d_pin !== 1'b0) begin n_bad++; $display("FAIL ed_start_bit got=%b want=0", ps2d_pin); end
    device_frame(1'b0, 1'b0, cap);
    wait_end(hung);
    // {stop=1, parity=1 (six ones), 0xED}
    n_cmp++; if (cap !== 10'h3ED) begin n_bad++; $display("FAIL ed_wire_bits got=%h want=3ed", cap); end
    n_cmp++; if (hung !== 1'b0) begin n_bad++; $display("FAIL ed_end got=busy want=idle"); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL ed_done_count got=%0d want=1", done_cnt); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL ed_err_count got=%0d want=0", err_cnt); end
    n_cmp++; if (post_busy !== 1'b0) begin n_bad++; $display("FAIL ed_busy_after_done got=%b want=0", post_busy); end
  endtask

  task automatic test_send_f4();
    int oe_cyc, d_cyc; logic n1_ok, busy_all, hung; logic [9:0] cap;
    clear_counts();
    repeat (10) @(negedge clk);
    start_tx(PS2_CMD_ENABLE, oe_cyc, d_cyc, n1_ok, busy_all);
    n_cmp++; if (oe_cyc != INH + 1) begin n_bad++; $display("FAIL f4_ps2c_oe_cycles got=%0d want=%0d", oe_cyc, INH + 1); end
    n_cmp++; if (busy_all !== 1'b1) begin n_bad++; $display("FAIL f4_busy_in_inhibit got=%b want=1", busy_all); end
    device_frame(1'b0, 1'b0, cap);
    wait_end(hung);
    n_cmp++; if (cap[8] !== 1'b0) begin n_bad++; $display("FAIL f4_parity got=%b want=0", cap[8]); end
    // {stop=1, parity=0 (five ones), 0xF4}
    n_cmp++; if (cap !== 10'h2F4) begin n_bad++; $display("FAIL f4_wire_bits got=%h want=2f4", cap); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL f4_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_nack();
    int oe_cyc, d_cyc; logic n1_ok, busy_all, hung; logic [9:0] cap;
    clear_counts();
    repeat (10) @(negedge clk);
    start_tx(PS2_CMD_ENABLE, oe_cyc, d_cyc, n1_ok, busy_all);
    device_frame(1'b1, 1'b0, cap);
    wait_end(hung);
    n_cmp++; if (err_cnt != 1) begin n_bad++; $display("FAIL nack_err_count got=%0d want=1", err_cnt); end
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL nack_done_count got=%0d want=0", done_cnt); end
    n_cmp++; if (post_busy !== 1'b0) begin n_bad++; $display("FAIL nack_busy_after_err got=%b want=0", post_busy); end
  endtask

  task automatic test_timeout();
    int oe_cyc, d_cyc, cnt; logic n1_ok, busy_all;
    clear_counts();
    repeat (10) @(negedge clk);
    start_tx(PS2_CMD_ENABLE, oe_cyc, d_cyc, n1_ok, busy_all);
    cnt = 0;
    while (!bus.err && cnt < TMO + 50) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++; if (cnt != TMO) begin n_bad++; $display("FAIL timeout_latency got=%0d want=%0d", cnt, TMO); end
    n_cmp++; if (ps2c_oe !== 1'b0) begin n_bad++; $display("FAIL timeout_ps2c_oe got=%b want=0", ps2c_oe); end
    @(negedge clk);
    n_cmp++; if (ps2d_oe !== 1'b0) begin n_bad++; $display("FAIL timeout_ps2d_oe got=%b want=0", ps2d_oe); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy got=%b want=0", bus.busy); end
    n_cmp++; if (err_cnt != 1 || done_cnt != 0) begin n_bad++; $display("FAIL timeout_pulses got=err%0d/done%0d want=err1/done0", err_cnt, done_cnt); end
  endtask

  task automatic test_rst_mid();
    int oe_cyc, d_cyc; logic n1_ok, busy_all, hung; logic [9:0] cap;
    clear_counts();
    repeat (10) @(negedge clk);
    start_tx(PS2_CMD_SET_LED, oe_cyc, d_cyc, n1_ok, busy_all);
    for (int k = 0; k < 5; k++) begin
      repeat (HALF) @(negedge clk);
      dev_c = 1'b0;
      if (k < 4) begin
        repeat (HALF) @(negedge clk);
        dev_c = 1'b1;
      end
    end
    repeat (14) @(negedge clk);
    // Fall 5 drives 0xED bit 4, which is 0.
    n_cmp++; if (ps2d_oe !== 1'b1) begin n_bad++; $display("FAIL rstmid_bit4_drive got=%b want=1", ps2d_oe); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({ps2c_oe, ps2d_oe, bus.busy} !== 3'b000) begin n_bad++; $display("FAIL rstmid_release got=%b want=000", {ps2c_oe, ps2d_oe, bus.busy}); end
    dev_c = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    n_cmp++; if (done_cnt != 0 || err_cnt != 0) begin n_bad++; $display("FAIL rstmid_pulses got=done%0d/err%0d want=0/0", done_cnt, err_cnt); end
    start_tx(PS2_CMD_RESET, oe_cyc, d_cyc, n1_ok, busy_all);
    device_frame(1'b0, 1'b0, cap);
    wait_end(hung);
    n_cmp++; if (cap !== 10'h3FF) begin n_bad++; $display("FAIL ff_wire_bits got=%h want=3ff", cap); end
    n_cmp++; if (done_cnt != 1 || err_cnt != 0) begin n_bad++; $display("FAIL ff_pulses got=done%0d/err%0d want=1/0", done_cnt, err_cnt); end
  endtask

  task automatic test_spurious();
    logic any_act = 1'b0;
    clear_counts();
    for (int r = 0; r < 3; r++) begin
      dev_c = 1'b0;
      repeat (15) begin @(negedge clk); if (bus.busy || ps2c_oe || ps2d_oe) any_act = 1'b1; end
      dev_c = 1'b1;
      repeat (15) begin @(negedge clk); if (bus.busy || ps2c_oe || ps2d_oe) any_act = 1'b1; end
    end
    n_cmp++; if (any_act !== 1'b0) begin n_bad++; $display("FAIL idle_spurious_fall got=active want=idle"); end
    n_cmp++; if (done_cnt != 0 || err_cnt != 0) begin n_bad++; $display("FAIL idle_spurious_pulses got=done%0d/err%0d want=0/0", done_cnt, err_cnt); end
  endtask

  task automatic test_back_to_back();
    int oe_cyc, d_cyc; logic n1_ok, busy_all, hung; logic [9:0] cap;
    clear_counts();
    start_tx(PS2_CMD_SET_LED, oe_cyc, d_cyc, n1_ok, busy_all);
    device_frame(1'b0, 1'b0, cap);
    wait_end(hung);
    start_tx(PS2_CMD_ENABLE, oe_cyc, d_cyc, n1_ok, busy_all);
    n_cmp++; if (n1_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_accepted got=%b want=1", n1_ok); end
    device_frame(1'b0, 1'b0, cap);
    wait_end(hung);
    n_cmp++; if (cap !== 10'h2F4) begin n_bad++; $display("FAIL b2b_wire_bits got=%h want=2f4", cap); end
    n_cmp++; if (done_cnt != 2) begin n_bad++; $display("FAIL b2b_done_count got=%0d want=2", done_cnt); end
  endtask

`ifdef PS2_TX_FILTER_EN
  task automatic test_filter();
    int oe_cyc, d_cyc; logic n1_ok, busy_all, hung; logic [9:0] cap;
    clear_counts();
    repeat (10) @(negedge clk);
    start_tx(PS2_CMD_SET_LED, oe_cyc, d_cyc, n1_ok, busy_all);
    device_frame(1'b0, 1'b1, cap);
    wait_end(hung);
    n_cmp++; if (cap !== 10'h3ED) begin n_bad++; $display("FAIL glitch_wire_bits got=%h want=3ed", cap); end
    n_cmp++; if (done_cnt != 1 || err_cnt != 0) begin n_bad++; $display("FAIL glitch_pulses got=done%0d/err%0d want=1/0", done_cnt, err_cnt); end
  endtask
`endif

  initial begin
    bus.wr  = 1'b0;
    bus.din = 8'h00;
    test_reset();
    test_send_ed();
    test_send_f4();
    test_nack();
    test_timeout();
    test_rst_mid();
    test_spurious();
    test_back_to_back();
`ifdef PS2_TX_FILTER_EN
    test_filter();
`endif
    n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL done_err_overlap got=%0d want=0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=still_running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset). It owns the open-collector ps2c/ps2d drive side of the same pins the keyboard receiver samples. It sits in the top-level I/O decode next to the keyboard block, driven by a CPU memory-mapped write strobe. It reports completion, busy and no-ack/timeout errors back to that decode.

## Interface
- INHIBIT_CYCLES, 5000: clk cycles ps2c is held low before start (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: max cycles from clock release to ack sampled (15 ms).
- FILTER_LEN, 8: consecutive equal samples needed to accept a ps2c level (only with filter compiled in).
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- ps2c  in  1  PS/2 clock pin level (async).
- ps2d  in  1  PS/2 data pin level (async).
- ps2c_oe  out  1  1 = pull ps2c low; 0 = release (tri-state at top).
- ps2d_oe  out  1  1 = pull ps2d low; 0 = release.
- wr  in  1  one-cycle request to send din.
- din  in  8  byte to send, captured on accepted wr.
- busy  out  1  transaction in progress; receiver must ignore the bus while high.
- done  out  1  one-cycle pulse, device acknowledged.
- err  out  1  one-cycle pulse, no ack or timeout.

## Operation
- ps2c and ps2d go through a 2-flop synchronizer; ps2c then goes through the optional filter; falling-edge detect yields fall, a one-cycle strobe.
- Frame = {stop=1, parity=~^din, din[7:0] LSB first}; start bit is 0.
- States:
  - IDLE: wr latches the frame, clears the counter, and moves to INHIBIT. wr is ignored in every other state.
  - INHIBIT: ps2c_oe=1 for INHIBIT_CYCLES, then goes to RTS.
  - RTS: for 1 cycle, ps2c_oe=1 and ps2d_oe=1 (start bit). Then go to SHIFT with ps2c_oe=0 and the timeout counter cleared.
  - SHIFT: on each fall, ps2d_oe = ~frame bit, bit index++. Fall 1..8 drive data, fall 9 drives parity, fall 10 drives stop (ps2d_oe=0). Then go to ACK.
  - ACK: on the next fall, sample ps2d. 0 moves to WAIT_IDLE; 1 pulses err and moves to IDLE.
  - WAIT_IDLE: wait for ps2c=1 and ps2d=1 (synchronized), then pulse done and go to IDLE.
- Timeout counter runs in SHIFT, ACK and WAIT_IDLE. Reaching TIMEOUT_CYCLES releases both lines, pulses err, and goes to IDLE.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, ps2c_oe=0, ps2d_oe=0, busy=0, done=0, err=0, bit index 0, counters 0.
- wr in IDLE at cycle n: busy=1 and ps2c_oe=1 at n+1.
- ps2c_oe deasserts exactly INHIBIT_CYCLES+1 cycles after the first ps2c_oe=1 cycle (inhibit plus one RTS cycle).
- The ps2d_oe update happens in the cycle after fall is seen. Latency from pin edge is 2 sync cycles, plus FILTER_LEN cycles when the filter is compiled in.
- done/err occur in the same cycle as the return to IDLE; busy=0 in the following cycle. done and err are never high together.
- A wr in the cycle busy drops is accepted.
- rst mid-transaction: both oe drop at the next edge and no done/err is issued. The device recovers on its own timeout.
- Spurious fall in IDLE/INHIBIT/RTS is ignored.
- Counters are sized with $clog2 of their parameter; no wrap: the counter saturates at terminal value.

## Configuration
- PS2_TX_FILTER_EN:
  - Defined: ps2c must hold a new level for FILTER_LEN consecutive cycles before it is accepted; shorter glitches produce no fall.
  - Undefined: the 2-flop synchronized ps2c feeds edge detect directly; FILTER_LEN is unused.

## Structure
- Shared package ps2_pkg:
  - state enum {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE};
  - FRAME_BITS=10;
  - command constants PS2_CMD_SET_LED=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF, PS2_ACK=8'hFA.
- Sub-module ps2_clk_filter: synchronizer, optional glitch filter, and fall strobe. The keyboard receiver may reuse it.

## Test plan
- Send 0xED with the device model clocking at 12.5 kHz and acking: wire bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1. Expect ps2d_oe low at fall 10, done pulse once, err never.
- Send 0xF4: parity bit 0 on fall 9. Inhibit holds ps2c_oe=1 for exactly 5000 cycles; busy is high throughout.
- Device leaves ps2d high at the ack fall: expect an err pulse, no done, and IDLE in the next cycle.
- Device never clocks after release: expect err exactly TIMEOUT_CYCLES cycles after ps2c_oe falls, with both oe at 0.
- Assert rst at fall 5: next cycle both oe=0, busy=0, no done/err. A new wr for 0xFF then completes with done.
- With PS2_TX_FILTER_EN, 3-cycle low glitches on ps2c during SHIFT leave the bit index unchanged. Without it, the same glitch advances the index (expected failure, documented).
